// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector: runtime-loadable pattern of 1..MAX_LEN
// bits, overlap/non-overlap mode, qualified input and a saturating match counter.
module seq_detector_prog #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               data_valid,
    input  logic               data_in,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [MAX_LEN-1:0] ONES      = '1;
    localparam logic [MAX_LEN-1:0] DEF_PAT   = MAX_LEN'(4'b0011);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;

    logic [MAX_LEN-1:0] hist_n;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_n;
    logic               match;
    logic               cfg_legal;

    // Next-state view of the accepted bit; only the low len bits take part in the compare.
    assign hist_n    = {hist_q[MAX_LEN-2:0], data_in};
    assign fill_n    = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
    assign len_mask  = ~(ONES << len_q);
    assign match     = (fill_n >= len_q) && ((hist_n & len_mask) == (pattern_q & len_mask));
    assign cfg_legal = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q   <= DEF_PAT;
            len_q       <= LEN_W'(4);
            overlap_q   <= 1'b1;
            hist_q      <= '0;
            fill_q      <= '0;
            detected    <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
        end else if (cfg_load) begin
            // A data bit arriving alongside a load is dropped in both the legal and illegal case.
            detected <= 1'b0;
            if (cfg_legal) begin
                pattern_q   <= cfg_pattern;
                len_q       <= cfg_len;
                overlap_q   <= cfg_overlap;
                hist_q      <= '0;
                fill_q      <= '0;
                match_count <= '0;
                cfg_err     <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
            end
        end else if (data_valid) begin
            hist_q   <= hist_n;
            detected <= match;
            if (match) begin
                if (match_count != '1) begin
                    match_count <= match_count + CNT_W'(1);
                end
                fill_q <= overlap_q ? fill_n : '0;
            end else begin
                fill_q <= fill_n;
            end
        end else begin
            detected <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares against two DUT instances.
module tb_seq_detector_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld1, ld2, dv1, dv2;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       data_in;
    logic       det1, det2, err1, err2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    seq_detector_prog #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_load(ld1), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .data_valid(dv1), .data_in(data_in),
        .detected(det1), .match_count(cnt1), .cfg_err(err1)
    );

    seq_detector_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_load(ld2), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .data_valid(dv2), .data_in(data_in),
        .detected(det2), .match_count(cnt2), .cfg_err(err2)
    );

    typedef struct {
        int    which;
        string tag;
        bit    det;
        int    cnt;
        bit    err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;
    int   exp_cnt[1:2];
    bit   exp_err[1:2];
    int   cnt_max[1:2];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.which == 1) begin
                check({e.tag, ".det1"}, int'(det1), int'(e.det));
                check({e.tag, ".cnt1"}, int'(cnt1), e.cnt);
                check({e.tag, ".err1"}, int'(err1), int'(e.err));
            end else begin
                check({e.tag, ".det2"}, int'(det2), int'(e.det));
                check({e.tag, ".cnt2"}, int'(cnt2), e.cnt);
                check({e.tag, ".err2"}, int'(err2), int'(e.err));
            end
        end
    end

    // One clock of stimulus; the expected outputs after that edge go to the scoreboard.
    task automatic cyc(input int which, input bit rst, input bit ld, input logic [7:0] pat,
                       input int len, input bit ovl, input bit v, input bit d, input bit exp_det);
        exp_t e;
        reset       = rst;
        ld1         = ld && (which == 1);
        ld2         = ld && (which == 2);
        dv1         = v && (which == 1);
        dv2         = v && (which == 2);
        cfg_pattern = pat;
        cfg_len     = 4'(len);
        cfg_overlap = ovl;
        data_in     = d;
        @(posedge clk);
        cyc_no++;
        if (rst) begin
            for (int w = 1; w <= 2; w++) begin
                exp_cnt[w] = 0;
                exp_err[w] = 1'b0;
                e = '{w, $sformatf("c%0d", cyc_no), 1'b0, 0, 1'b0};
                q.push_back(e);
            end
        end else begin
            if (ld) begin
                if (len >= 1 && len <= 8) begin
                    exp_cnt[which] = 0;
                    exp_err[which] = 1'b0;
                end else begin
                    exp_err[which] = 1'b1;
                end
            end else if (exp_det && exp_cnt[which] < cnt_max[which]) begin
                exp_cnt[which]++;
            end
            e = '{which, $sformatf("c%0d", cyc_no), exp_det, exp_cnt[which], exp_err[which]};
            q.push_back(e);
        end
        #1;
    endtask

    task automatic do_reset();
        cyc(1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input int which, input logic [7:0] pat, input int len, input bit ovl,
                        input bit v, input bit d);
        cyc(which, 1'b0, 1'b1, pat, len, ovl, v, d, 1'b0);
    endtask

    task automatic idle(input int which);
        cyc(which, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic stream(input int which, input string bits, input string dets);
        for (int i = 0; i < bits.len(); i++) begin
            cyc(which, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, bits[i] == "1", dets[i] == "1");
        end
    endtask

    initial begin
        string gap_bits;
        cnt_max[1] = 255;
        cnt_max[2] = 3;
        gap_bits   = "0011";

        do_reset();
        do_reset();

        // Default 0011, overlap on
        stream(1, "0001100110110010", "0000100010000000");

        // Pattern 101: overlap on, overlap off, and fresh-bits requirement
        load(1, 8'b101, 3, 1'b1, 1'b1, 1'b0);
        stream(1, "10101", "00101");
        load(1, 8'b101, 3, 1'b0, 1'b0, 1'b0);
        stream(1, "10101", "00100");
        load(1, 8'b101, 3, 1'b0, 1'b0, 1'b0);
        stream(1, "101101", "001001");

        // Default pattern with data_valid gaps
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, gap_bits[i] == "1", i == 3);
            for (int g = 0; g < 3; g++) idle(1);
        end

        // Illegal lengths keep the config and history; legal load clears the error
        load(1, 8'hFF, 0, 1'b0, 1'b1, 1'b1);
        load(1, 8'hFF, 9, 1'b0, 1'b0, 1'b0);
        stream(1, "0011", "0001");
        idle(1);
        load(1, 8'b0011, 4, 1'b1, 1'b0, 1'b0);
        idle(1);

        // CNT_W=2 saturation, pattern "1"; the bit sent with the load is dropped
        load(2, 8'b1, 1, 1'b1, 1'b1, 1'b1);
        stream(2, "111110", "111110");

        // Reset mid-pattern discards partial history
        do_reset();
        stream(1, "001", "000");
        do_reset();
        stream(1, "1", "0");
        stream(1, "0011", "0001");
        idle(1);

        reset = 1'b0; ld1 = 1'b0; ld2 = 1'b0; dv1 = 1'b0; dv2 = 1'b0;
        repeat (2) @(posedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Programmable serial bit-pattern detector, the parametrised successor to the fixed "0011" sequence detector. It adds a runtime-loadable pattern of 1..MAX_LEN bits, an overlap/non-overlap mode, input qualification via `data_valid`, and a saturating match counter. It sits on a 1-bit serial stream and flags each completed pattern with a one-cycle registered pulse. Reset defaults reproduce the predecessor's behaviour: pattern 0011, length 4, overlap on.

## Interface
- MAX_LEN, 8: maximum pattern length in bits; must be >= 4.
- CNT_W, 8: width of `match_count`.
- LEN_W, $clog2(MAX_LEN)+1 (derived, not overridden): width of `cfg_len`.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock, and reset is synchronous and active-high.
- cfg_load  in  1  captures `cfg_pattern`, `cfg_len` and `cfg_overlap` this cycle.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is received first, bit [0] last.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- data_valid  in  1  qualifies `data_in`.
- data_in  in  1  serial input bit.
- detected  out  1  one-cycle pulse per match.
- match_count  out  CNT_W  saturating count of matches.
- cfg_err  out  1  sticky flag for an illegal `cfg_len` on load.

## Operation
- Internal state: active pattern/len/overlap registers, history shift register `hist[MAX_LEN-1:0]`, fill counter `fill` (0..MAX_LEN).
- Reset values: pattern = 0011 (zero-extended), len = 4, overlap = 1, hist = 0, fill = 0, detected = 0, match_count = 0, cfg_err = 0.
- Priority per cycle: reset > cfg_load > data_valid.
- cfg_load with 1 <= cfg_len <= MAX_LEN:
  - Config registers take the new values; hist, fill and match_count clear; detected = 0; cfg_err clears.
  - A `data_valid` bit in the same cycle is dropped.
- cfg_load with cfg_len = 0 or cfg_len > MAX_LEN:
  - Config is unchanged; cfg_err = 1 (sticky until a legal load or reset).
  - hist, fill and match_count are unchanged; the same-cycle data bit is still dropped.
- Accepted bit (data_valid = 1, no load):
  - hist_n = {hist[MAX_LEN-2:0], data_in}; fill_n = min(fill+1, MAX_LEN).
  - Match when fill_n >= len and hist_n[len-1:0] == pattern[len-1:0].
  - On a match: detected <= 1; match_count increments, saturating at 2^CNT_W-1 (holds there).
  - On a match with overlap = 0: fill <= 0, so the next match needs len fresh bits. With overlap = 1, fill <= fill_n.
- data_valid = 0: hist, fill and match_count hold; detected <= 0.
- Bits of hist above len are ignored in the compare.

## Timing
- Latency: `detected` is registered. It goes high at the posedge that samples the final pattern bit and stays high for exactly one cycle. It returns low at the next posedge unless that posedge is also a match.
- Back-to-back matches (e.g. len 1, overlap on) hold `detected` high on consecutive cycles.
- `match_count` updates on the same edge as `detected`.
- `cfg_err` updates on the load edge.
- New config is effective for the first bit accepted after the load edge.
- Reset mid-pattern: partial history is discarded, so no match can complete using pre-reset bits.

## Test plan
- Default config, data_valid held at 1, stream 0001100110110010 (first bit leftmost): `detected` pulses only after bit indices 4 and 8; match_count = 2.
- Load pattern 101 (len 3), overlap = 1, stream 10101: pulses after bits 2 and 4; count = 2. Reload with overlap = 0 and send the same stream: one pulse after bit 2; count = 1. Stream 101101 with overlap = 0: pulses after bits 2 and 5.
- Default config, stream 0,0,1,1 with data_valid low for 3 cycles between each bit: exactly one pulse, in the cycle after the final 1; `detected` stays 0 through all gap cycles; count = 1.
- cfg_load with cfg_len = 0, then with cfg_len = MAX_LEN+1: cfg_err = 1 and the default 0011 pattern still detects. A following legal load clears cfg_err to 0.
- CNT_W = 2, pattern 1 (len 1), five consecutive valid 1s: `detected` high for 5 consecutive cycles; match_count goes 1, 2, 3, 3, 3.
- Default config, send 0,0,1, assert reset for one cycle, then send 1: no pulse; match_count = 0. Then send 0,0,1,1: one pulse.
